// File: rtl/drive_phase_accum_pkg.sv
// Shared drive-path definitions: accumulator geometry and the helper that
// maps a global qubit index onto its (bank, local index) location.
package drive_phase_accum_pkg;

    localparam int NUM_BANK                  = 2;
    localparam int NUM_QUBIT_PER_BANK        = 16;
    localparam int QUBIT_ADDR_WIDTH_PER_BANK = 4;
    localparam int Z_CORR_WIDTH              = 12;
    localparam int TOTAL_QUBIT               = NUM_BANK * NUM_QUBIT_PER_BANK;
    localparam int BANK_IDX_WIDTH            = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

    // One phase word; the unit is 2*pi / 2**Z_CORR_WIDTH, so plain modular
    // addition is exactly phase rotation.
    typedef logic [Z_CORR_WIDTH-1:0] phase_t;

    typedef struct packed {
        logic [BANK_IDX_WIDTH-1:0]            bank;
        logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0] local_idx;
    } qubit_loc_t;

    // Bank b owns the contiguous global range b*NUM_QUBIT_PER_BANK upward.
    function automatic qubit_loc_t qubit_to_loc(input int unsigned q);
        qubit_loc_t loc;
        loc.bank      = BANK_IDX_WIDTH'(q / NUM_QUBIT_PER_BANK);
        loc.local_idx = QUBIT_ADDR_WIDTH_PER_BANK'(q % NUM_QUBIT_PER_BANK);
        return loc;
    endfunction

endpackage

// File: rtl/drive_phase_accum_if.sv
// Bus between the Z-correction table / NCO side and the phase accumulator.
interface drive_phase_accum_if;
    import drive_phase_accum_pkg::*;

    logic [TOTAL_QUBIT*Z_CORR_WIDTH-1:0]           z_corr_in;
    logic [NUM_BANK-1:0]                           valid_z_corr_in;
    logic [NUM_BANK-1:0]                           rz_mode_in;
    logic [NUM_BANK-1:0]                           phase_clr;
    logic [NUM_BANK-1:0]                           rd_en;
    logic [NUM_BANK*QUBIT_ADDR_WIDTH_PER_BANK-1:0] rd_addr;
    logic [NUM_BANK*Z_CORR_WIDTH-1:0]              phase_out;
    logic [NUM_BANK-1:0]                           phase_valid_out;

    modport master (
        output z_corr_in, valid_z_corr_in, rz_mode_in, phase_clr, rd_en, rd_addr,
        input  phase_out, phase_valid_out
    );

    modport slave (
        input  z_corr_in, valid_z_corr_in, rz_mode_in, phase_clr, rd_en, rd_addr,
        output phase_out, phase_valid_out
    );

endinterface

// File: rtl/drive_phase_accum_bank.sv
// One bank of virtual-Z accumulators: all qubits update together from the
// shared vector, bank-wide clear wins over update, and a registered read port
// returns the pre-update value of the addressed qubit.
module drive_phase_accum_bank
    import drive_phase_accum_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_QUBIT_PER_BANK*Z_CORR_WIDTH-1:0] corr,
    input  logic                                       en,
    input  logic                                       clr,
    input  logic                                       rd_en,
    input  logic [QUBIT_ADDR_WIDTH_PER_BANK-1:0]       rd_addr,
    output phase_t                                     phase,
    output logic                                       phase_valid
);

    phase_t acc_r [NUM_QUBIT_PER_BANK];
    phase_t phase_r;
    logic   phase_valid_r;

    // Accumulator array: clear has priority, otherwise add with the carry dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_QUBIT_PER_BANK; i++) begin
                acc_r[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NUM_QUBIT_PER_BANK; i++) begin
                acc_r[i] <= '0;
            end
        end else if (en) begin
            for (int i = 0; i < NUM_QUBIT_PER_BANK; i++) begin
                acc_r[i] <= acc_r[i] + corr[i*Z_CORR_WIDTH +: Z_CORR_WIDTH];
            end
        end
    end

    // Read port: samples the current (pre-update) accumulator, holds data when idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_r       <= '0;
            phase_valid_r <= 1'b0;
        end else begin
            phase_valid_r <= rd_en;
            if (rd_en) begin
                phase_r <= acc_r[rd_addr];
            end
        end
    end

    assign phase       = phase_r;
    assign phase_valid = phase_valid_r;

endmodule

// File: rtl/drive_phase_accum.sv
// Per-qubit virtual-Z phase accumulator. Decides which banks update this
// cycle (RZ immediates pre-empt crosstalk corrections, since both share one
// vector) and fans the correction slices out to the bank instances.
module drive_phase_accum
    import drive_phase_accum_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    drive_phase_accum_if.slave  bus
);

    localparam int BANK_VEC_WIDTH = NUM_QUBIT_PER_BANK * Z_CORR_WIDTH;

    logic [NUM_BANK-1:0]       rz_hit_s;
    logic                      any_rz_s;
    logic                      xt_hit_s;
    logic [NUM_BANK-1:0]       en_s;
    logic [BANK_VEC_WIDTH-1:0] bank_corr_s [NUM_BANK];

    // Update enables: any RZ bank restricts the update to RZ banks only;
    // otherwise a crosstalk vector from any bank updates every qubit.
    always_comb begin
        rz_hit_s = bus.valid_z_corr_in & bus.rz_mode_in;
        any_rz_s = |rz_hit_s;
        xt_hit_s = (|(bus.valid_z_corr_in & ~bus.rz_mode_in)) & ~any_rz_s;
        en_s     = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            if (any_rz_s) begin
                en_s[b] = rz_hit_s[b];
            end else begin
                en_s[b] = xt_hit_s;
            end
        end
    end

    // Route each global qubit slice to its owning bank's local position.
    always_comb begin
        qubit_loc_t loc;
        loc = '0;
        for (int b = 0; b < NUM_BANK; b++) begin
            bank_corr_s[b] = '0;
        end
        for (int q = 0; q < TOTAL_QUBIT; q++) begin
            loc = qubit_to_loc(q);
            bank_corr_s[loc.bank][int'(loc.local_idx)*Z_CORR_WIDTH +: Z_CORR_WIDTH] =
                bus.z_corr_in[q*Z_CORR_WIDTH +: Z_CORR_WIDTH];
        end
    end

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        drive_phase_accum_bank u_bank (
            .clk         (clk),
            .rst         (rst),
            .corr        (bank_corr_s[b]),
            .en          (en_s[b]),
            .clr         (bus.phase_clr[b]),
            .rd_en       (bus.rd_en[b]),
            .rd_addr     (bus.rd_addr[b*QUBIT_ADDR_WIDTH_PER_BANK +: QUBIT_ADDR_WIDTH_PER_BANK]),
            .phase       (bus.phase_out[b*Z_CORR_WIDTH +: Z_CORR_WIDTH]),
            .phase_valid (bus.phase_valid_out[b])
        );
    end

endmodule

// File: tb/tb_drive_phase_accum.sv
// Self-checking bench for drive_phase_accum: a phase-arithmetic model checked
// every cycle, plus directed scenarios with hand-computed read-back values.
module tb_drive_phase_accum;
    import drive_phase_accum_pkg::*;

    localparam int NQ = NUM_QUBIT_PER_BANK;
    localparam int ZW = Z_CORR_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    drive_phase_accum_if bus();

    drive_phase_accum dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    phase_t              m_acc   [TOTAL_QUBIT];
    phase_t              m_phase [NUM_BANK];
    logic [NUM_BANK-1:0] m_valid;

    logic [NUM_BANK-1:0] v_w;
    logic [NUM_BANK-1:0] r_w;
    assign v_w = bus.valid_z_corr_in;
    assign r_w = bus.rz_mode_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase registers as plain modular integers per qubit.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int q = 0; q < TOTAL_QUBIT; q++) m_acc[q] <= '0;
            for (int b = 0; b < NUM_BANK; b++) m_phase[b] <= '0;
            m_valid <= '0;
        end else begin
            for (int q = 0; q < TOTAL_QUBIT; q++) begin
                if (bus.phase_clr[q / NQ])
                    m_acc[q] <= '0;
                else if ((|(v_w & r_w)) ? (v_w[q / NQ] & r_w[q / NQ]) : (|(v_w & ~r_w)))
                    m_acc[q] <= phase_t'((int'(m_acc[q]) + int'(bus.z_corr_in[q*ZW +: ZW])) % 4096);
            end
            for (int b = 0; b < NUM_BANK; b++) begin
                m_valid[b] <= bus.rd_en[b];
                if (bus.rd_en[b])
                    m_phase[b] <= m_acc[b*NQ + int'(bus.rd_addr[b*4 +: 4])];
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            for (int b = 0; b < NUM_BANK; b++) begin
                chk($sformatf("cycle_valid_b%0d", b), 32'(bus.phase_valid_out[b]), 32'(m_valid[b]));
                chk($sformatf("cycle_phase_b%0d", b), 32'(bus.phase_out[b*ZW +: ZW]), 32'(m_phase[b]));
            end
        end
    end

    task automatic idle();
        bus.valid_z_corr_in = '0;
        bus.rz_mode_in      = '0;
        bus.phase_clr       = '0;
        bus.rd_en           = '0;
        bus.rd_addr         = '0;
        bus.z_corr_in       = '0;
    endtask

    task automatic set_bank(input int b, input phase_t val);
        for (int q = 0; q < NQ; q++) bus.z_corr_in[(b*NQ + q)*ZW +: ZW] = val;
    endtask

    task automatic upd(input logic [1:0] valid, input logic [1:0] rz, input logic [1:0] clr);
        bus.valid_z_corr_in = valid;
        bus.rz_mode_in      = rz;
        bus.phase_clr       = clr;
        @(negedge clk);
        idle();
    endtask

    task automatic rd(input string name, input logic [1:0] en, input logic [3:0] a0,
                      input logic [3:0] a1, input phase_t e0, input phase_t e1);
        bus.rd_en   = en;
        bus.rd_addr = {a1, a0};
        @(negedge clk);
        idle();
        chk({name, "_valid"}, 32'(bus.phase_valid_out), 32'(en));
        if (en[0]) chk({name, "_b0"}, 32'(bus.phase_out[11:0]), 32'(e0));
        if (en[1]) chk({name, "_b1"}, 32'(bus.phase_out[23:12]), 32'(e1));
    endtask

    initial begin
        idle();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_phase", 32'(bus.phase_out), 32'h0);
        chk("reset_valid", 32'(bus.phase_valid_out), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Mid-stream asynchronous reset with an update in flight.
        set_bank(0, 12'h123);
        set_bank(1, 12'h123);
        bus.valid_z_corr_in = 2'b01;
        @(negedge clk);
        bus.rd_en   = 2'b11;
        bus.rd_addr = {4'd5, 4'd5};
        @(posedge clk);
        #2;
        chk("pre_reset_phase", 32'(bus.phase_out), 32'h123123);
        rst = 1'b0;
        #1;
        chk("async_reset_phase", 32'(bus.phase_out), 32'h0);
        chk("async_reset_valid", 32'(bus.phase_valid_out), 32'h0);
        idle();
        @(negedge clk);
        rst = 1'b1;
        rd("post_reset_q5", 2'b11, 4'd5, 4'd5, 12'h000, 12'h000);

        // Crosstalk accumulate: three adds of 0x010 reach every qubit.
        for (int i = 0; i < 3; i++) begin
            set_bank(0, 12'h010);
            set_bank(1, 12'h010);
            upd(2'b01, 2'b00, 2'b00);
        end
        rd("xt_accum_b1q3", 2'b10, 4'd0, 4'd3, 12'h000, 12'h030);
        rd("xt_accum_b0q15", 2'b01, 4'd15, 4'd0, 12'h030, 12'h000);
        for (int q = 0; q < TOTAL_QUBIT; q++) chk($sformatf("model_xt_q%0d", q), 32'(m_acc[q]), 32'h030);

        // RZ per bank; the crosstalk vector of bank 0 is dropped.
        upd(2'b00, 2'b00, 2'b11);
        set_bank(0, 12'h100);
        set_bank(1, 12'h100);
        upd(2'b11, 2'b10, 2'b00);
        rd("rz_mixed", 2'b11, 4'd4, 4'd4, 12'h000, 12'h100);
        set_bank(0, 12'h050);
        set_bank(1, 12'h7FF);
        upd(2'b01, 2'b01, 2'b00);
        rd("rz_bank0_only", 2'b11, 4'd6, 4'd6, 12'h050, 12'h100);
        // rz flag without valid does not count as an RZ hit.
        set_bank(0, 12'h001);
        set_bank(1, 12'h001);
        upd(2'b01, 2'b10, 2'b00);
        rd("rz_flag_no_valid", 2'b11, 4'd7, 4'd7, 12'h051, 12'h101);

        // Wrap-around modulo 2^12.
        upd(2'b00, 2'b00, 2'b11);
        bus.z_corr_in[11:0] = 12'hFF0;
        upd(2'b01, 2'b00, 2'b00);
        bus.z_corr_in[11:0] = 12'h020;
        upd(2'b01, 2'b00, 2'b00);
        rd("wrap_q0", 2'b01, 4'd0, 4'd0, 12'h010, 12'h000);
        rd("wrap_q1", 2'b01, 4'd1, 4'd0, 12'h000, 12'h000);
        chk("model_wrap", 32'(m_acc[0]), 32'h010);

        // Clear beats update on bank 0; a same-cycle read sees old values.
        upd(2'b00, 2'b00, 2'b11);
        set_bank(0, 12'h003);
        set_bank(1, 12'h003);
        upd(2'b01, 2'b00, 2'b00);
        set_bank(0, 12'h005);
        set_bank(1, 12'h005);
        bus.phase_clr       = 2'b01;
        bus.valid_z_corr_in = 2'b01;
        bus.rd_en           = 2'b11;
        bus.rd_addr         = {4'd1, 4'd1};
        @(negedge clk);
        idle();
        chk("clr_read_old", 32'(bus.phase_out), 32'h003003);
        rd("clr_after", 2'b11, 4'd1, 4'd1, 12'h000, 12'h008);

        // Read/update collision, crosstalk arriving via bank 1 valid.
        upd(2'b00, 2'b00, 2'b11);
        bus.z_corr_in[2*ZW +: ZW] = 12'h007;
        upd(2'b01, 2'b00, 2'b00);
        bus.z_corr_in[2*ZW +: ZW] = 12'h001;
        bus.valid_z_corr_in = 2'b10;
        bus.rd_en           = 2'b01;
        bus.rd_addr         = {4'd0, 4'd2};
        @(negedge clk);
        idle();
        chk("collide_old", 32'(bus.phase_out[11:0]), 32'h007);
        rd("collide_next", 2'b01, 4'd2, 4'd0, 12'h008, 12'h000);

        // Idle: data holds, valid drops.
        @(negedge clk);
        chk("hold_valid", 32'(bus.phase_valid_out), 32'h0);
        chk("hold_phase", 32'(bus.phase_out[11:0]), 32'h008);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drive_phase_accum.md
# drive_phase_accum

Per-qubit virtual-Z phase accumulator that sits directly downstream of the drive Z-correction table in the drive circuit. Each cycle in which the Z-correction table presents a valid correction vector, the block adds the corrections into one modular phase register per qubit. Two correction kinds are handled: crosstalk corrections, which apply to all qubits, and RZ immediates, which apply per bank. On request, each bank reads back the accumulated phase of one of its qubits to feed the drive NCO.

## Interface
- NUM_BANK, 2, number of banks; each bank has independent valid, RZ, clear and read signals.
- NUM_QUBIT_PER_BANK, 16, qubits per bank; total qubits TOTAL_QUBIT = NUM_BANK*NUM_QUBIT_PER_BANK.
- QUBIT_ADDR_WIDTH_PER_BANK, 4, width of the per-bank qubit address.
- Z_CORR_WIDTH, 12, width of one correction and of one accumulator; the unit is 2π/2^Z_CORR_WIDTH.
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- z_corr_in  in  TOTAL_QUBIT*Z_CORR_WIDTH  correction vector; slice q belongs to global qubit q, and bank b owns qubits b*NUM_QUBIT_PER_BANK..(b+1)*NUM_QUBIT_PER_BANK-1.
- valid_z_corr_in  in  NUM_BANK  per-bank valid for z_corr_in.
- rz_mode_in  in  NUM_BANK  per-bank flag: the vector carries an RZ immediate rather than a crosstalk correction.
- phase_clr  in  NUM_BANK  synchronous clear of every accumulator in bank b.
- rd_en  in  NUM_BANK  per-bank read request.
- rd_addr  in  NUM_BANK*QUBIT_ADDR_WIDTH_PER_BANK  per-bank local qubit index.
- phase_out  out  NUM_BANK*Z_CORR_WIDTH  read data, registered.
- phase_valid_out  out  NUM_BANK  read data valid.

## Operation
- Signals used below:
  - rz_hit[b] = valid_z_corr_in[b] & rz_mode_in[b].
  - any_rz = |rz_hit.
  - xt_hit = (|(valid_z_corr_in & ~rz_mode_in)) & ~any_rz.
- Update enable for qubit q in bank b:
  - If any_rz: en_q = rz_hit[b].
  - Otherwise: en_q = xt_hit.
- Accumulator update: acc_q <= acc_q + z_corr_in slice q, modulo 2^Z_CORR_WIDTH.
  - The carry is discarded; wrap-around is the intended behaviour (0xFFF + 0x002 = 0x001).
- Mixed cycles: when some banks are valid in RZ mode and others are valid in crosstalk mode in the same cycle, only the RZ banks update. The crosstalk contribution is dropped. This matches the single shared vector format.
- Clear: phase_clr[b] sets every accumulator in bank b to 0.
  - Clear takes priority over an update to the same bank in the same cycle; the result is 0, not 0 + correction.
  - Clear has no effect on other banks.
- Read: rd_en[b] registers acc of (bank b, rd_addr[b]) into phase_out slice b.
  - The read samples the pre-update value of the same cycle; there is no bypass.
  - Banks read independently.
- Without rd_en, phase_out holds its last value and phase_valid_out[b] falls to 0.
- rd_addr is never out of range: NUM_QUBIT_PER_BANK = 2^QUBIT_ADDR_WIDTH_PER_BANK.

## Timing
- Reset (rst = 0, asynchronous) forces the following to 0, with immediate effect at any point in operation:
  - every accumulator;
  - phase_out;
  - phase_valid_out.
- Updates that are in flight when reset asserts are lost. No partial update is visible after release.
- Update latency: a correction presented at edge N is visible in acc at edge N+1. It is readable on phase_out at edge N+2 if rd_en is asserted in cycle N+1.
- Read latency: 1 cycle from rd_en to phase_out / phase_valid_out.
- Throughput: one update per cycle and one read per bank per cycle, with no stalls and no backpressure.
- Clear latency: 1 cycle. A read in the same cycle as phase_clr returns the pre-clear value.

## Structure
- The shared drive package holds:
  - the Z_CORR_WIDTH default;
  - the helper that maps a global qubit index to (bank, local index).
- One sub-module, drive_phase_accum_bank, instantiated NUM_BANK times. Each instance contains:
  - NUM_QUBIT_PER_BANK accumulators;
  - clear logic;
  - the read mux and output register.
- The top level computes any_rz / xt_hit and distributes the per-qubit slices and enables to the banks.
- The accumulators are flops, not SRAM. A same-cycle read-modify-write of all qubits is required.

## Test plan
All scenarios use default parameters.
- Reset: assert rst = 0 mid-stream, then release → all phase_out = 0 and phase_valid_out = 0. Reading qubit 5 in both banks returns 0.
- Crosstalk accumulate: valid = 2'b01, rz = 0, every slice = 0x010, for 3 consecutive cycles; then rd_en bank1 with addr 3 → phase_out[1] = 0x030 two cycles after the last update. All 32 qubits hold 0x030.
- RZ per bank and mixed cycle:
  - valid = 2'b11, rz = 2'b10, bank-1 slices = 0x100 → only bank 1 becomes 0x100; bank 0 is unchanged.
  - The crosstalk contribution from bank 0 is dropped.
- Wrap-around: preload qubit 0 to 0xFF0 using crosstalk slices, then add 0x020 → the read returns 0x010.
- Clear vs update: in the same cycle, phase_clr = 2'b01 and valid = 2'b01 with slices = 0x005 → bank 0 = 0x000, bank 1 = 0x005. A read in that cycle returns the old values.
- Read/update collision: rd_en on qubit 2 in the same cycle as adding 0x001 to an accumulator holding 0x007 → returns 0x007. The next read returns 0x008.
